// File: rtl/dmem_arbiter_if.sv
// Bundle between the data-memory arbiter, its two requesters and the memory.
// Ports: p0_*/p1_* request, grant and read-return signals for each requester;
//        mem_* single-port memory command and read data.
// slave modport = arbiter view; master modport = requesters + memory model view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 = MEM stage, port 1 = loader/debug.
// Latency: grant same cycle as request (combinational); read data/rvalid one cycle after grant.
// Backpressure: the losing port sees gnt=0 and holds its request; port 0 stalls on p0_req & ~p0_gnt.
// Ports: i_clk (rising edge), i_reset (async, active-high), io_bus (dmem_arbiter_if.slave).
// Build option: DMEM_ARB_RR_EN selects round-robin instead of fixed priority + starvation guard.
module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4    // 1..15, used only in fixed-priority mode
) (
  input  logic          i_clk,
  input  logic          i_reset,
  dmem_arbiter_if.slave io_bus
);

  logic              w_p0_gnt;
  logic              w_p1_gnt;
  logic              w_rd_gnt;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Read-return tag: a read was granted last cycle, and by which port.
  logic              r_rd_pend;
  logic              r_rd_port;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic              w_p0_rvalid;
  logic              w_p1_rvalid;

`ifdef DMEM_ARB_RR_EN
  // 0 = port 0 was the last winner.
  logic r_last_owner;

  // Grants are gated with reset so nothing reaches the memory while reset is high.
  always_comb begin
    w_p0_gnt = 1'b0;
    w_p1_gnt = 1'b0;
    if (!i_reset) begin
      if (io_bus.p0_req && io_bus.p1_req) begin
        w_p1_gnt = ~r_last_owner;
        w_p0_gnt = r_last_owner;
      end else begin
        w_p0_gnt = io_bus.p0_req;
        w_p1_gnt = io_bus.p1_req;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last_owner <= 1'b0;
    end else if (w_p0_gnt || w_p1_gnt) begin
      r_last_owner <= w_p1_gnt;
    end
  end
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Consecutive cycles port 1 has been requesting without a grant.
  logic [3:0] r_wait_cnt;
  logic       w_force_p1;

  assign w_force_p1 = (r_wait_cnt == MAX_WAIT_C);

  always_comb begin
    w_p0_gnt = 1'b0;
    w_p1_gnt = 1'b0;
    if (!i_reset) begin
      w_p1_gnt = io_bus.p1_req & (w_force_p1 | ~io_bus.p0_req);
      w_p0_gnt = io_bus.p0_req & ~w_p1_gnt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait_cnt <= 4'd0;
    end else if (io_bus.p1_req && !w_p1_gnt) begin
      if (r_wait_cnt != MAX_WAIT_C) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end
`endif

  // Memory command muxed from the winner; all zero when idle.
  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_p1_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = io_bus.p1_we;
      w_mem_addr  = io_bus.p1_addr;
      w_mem_wdata = io_bus.p1_wdata;
    end else if (w_p0_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = io_bus.p0_we;
      w_mem_addr  = io_bus.p0_addr;
      w_mem_wdata = io_bus.p0_wdata;
    end
  end

  assign w_rd_gnt = w_mem_en & ~w_mem_we;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_pend <= 1'b0;
      r_rd_port <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_gnt;
      r_rd_port <= w_rd_gnt & w_p1_gnt;
    end
  end

  assign w_p0_rvalid = r_rd_pend & ~r_rd_port;
  assign w_p1_rvalid = r_rd_pend &  r_rd_port;

  // Hold registers keep the last returned word per port between reads.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (w_p0_rvalid) r_p0_rdata <= io_bus.mem_rdata;
      if (w_p1_rvalid) r_p1_rdata <= io_bus.mem_rdata;
    end
  end

  assign io_bus.p0_gnt    = w_p0_gnt;
  assign io_bus.p1_gnt    = w_p1_gnt;
  assign io_bus.p0_rvalid = w_p0_rvalid;
  assign io_bus.p1_rvalid = w_p1_rvalid;
  // The returning word is forwarded in the rvalid cycle, then held.
  assign io_bus.p0_rdata  = w_p0_rvalid ? io_bus.mem_rdata : r_p0_rdata;
  assign io_bus.p1_rdata  = w_p1_rvalid ? io_bus.mem_rdata : r_p1_rdata;
  assign io_bus.mem_en    = w_mem_en;
  assign io_bus.mem_we    = w_mem_we;
  assign io_bus.mem_addr  = w_mem_addr;
  assign io_bus.mem_wdata = w_mem_wdata;

endmodule
